// File: rtl/nn_layer_sequencer.sv
// Layer/neuron/input sequencer for a fully connected NN engine.
// Issues MAC beats per input and one activation request per neuron.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for start; the config is latched on start
// S_CHECK | one cycle to validate the latched config
// S_MAC   | one MAC beat per input of the current neuron
// S_ACT   | activation request for the current neuron
// S_DONE  | one-cycle completion pulse
module nn_layer_sequencer #(
  parameter int MAX_LAYERS = 5,
  parameter int NW         = 6,
  parameter int AFW        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NW-1:0]             no_layers,
  input  logic [NW-1:0]             n_in,
  input  logic [MAX_LAYERS*NW-1:0]  nl_flat,
  input  logic [MAX_LAYERS*AFW-1:0] af_flat,
  output logic                      mac_valid,
  input  logic                      mac_ready,
  output logic                      mac_first,
  output logic                      mac_last,
  output logic                      act_valid,
  input  logic                      act_ready,
  output logic [AFW-1:0]            af_sel,
  output logic [NW-1:0]             layer_idx,
  output logic [NW-1:0]             neuron_idx,
  output logic [NW-1:0]             input_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MAC, S_ACT, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [NW-1:0]             no_layers_q, n_in_q;
  logic [MAX_LAYERS*NW-1:0]  nl_q;
  logic [MAX_LAYERS*AFW-1:0] af_q;
  logic [NW-1:0]             layer_nxt, neuron_nxt, input_nxt;
  logic                      err_nxt;
  logic                      cfg_bad;
  logic [NW-1:0]             k_cur, nl_cur;
  logic [AFW-1:0]            af_cur;

  always_comb begin
    cfg_bad = (no_layers_q == '0) || (no_layers_q > NW'(MAX_LAYERS)) || (n_in_q == '0);
    for (int k = 0; k < MAX_LAYERS; k++) begin
      if ((NW'(k) < no_layers_q) && (nl_q[k*NW +: NW] == '0)) cfg_bad = 1'b1;
    end
  end

  // Per-layer selects: input count comes from the previous layer's width.
  always_comb begin
    k_cur  = n_in_q;
    nl_cur = '0;
    af_cur = '0;
    for (int k = 0; k < MAX_LAYERS; k++) begin
      if (layer_idx == NW'(k)) begin
        nl_cur = nl_q[k*NW +: NW];
        af_cur = af_q[k*AFW +: AFW];
      end
      if ((k < MAX_LAYERS - 1) && (layer_idx == NW'(k + 1))) k_cur = nl_q[k*NW +: NW];
    end
  end

  always_comb begin
    state_nxt  = state;
    layer_nxt  = layer_idx;
    neuron_nxt = neuron_idx;
    input_nxt  = input_idx;
    err_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_CHECK;
          layer_nxt  = '0;
          neuron_nxt = '0;
          input_nxt  = '0;
        end
      end
      S_CHECK: begin
        if (cfg_bad) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (mac_ready) begin
          if (input_idx == k_cur - 1'b1) state_nxt = S_ACT;
          else                           input_nxt = input_idx + 1'b1;
        end
      end
      S_ACT: begin
        if (act_ready) begin
          input_nxt = '0;
          if (neuron_idx != nl_cur - 1'b1) begin
            neuron_nxt = neuron_idx + 1'b1;
            state_nxt  = S_MAC;
          end else if (layer_idx != no_layers_q - 1'b1) begin
            neuron_nxt = '0;
            layer_nxt  = layer_idx + 1'b1;
            state_nxt  = S_MAC;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      layer_idx   <= '0;
      neuron_idx  <= '0;
      input_idx   <= '0;
      err         <= 1'b0;
      no_layers_q <= '0;
      n_in_q      <= '0;
      nl_q        <= '0;
      af_q        <= '0;
    end else begin
      state      <= state_nxt;
      layer_idx  <= layer_nxt;
      neuron_idx <= neuron_nxt;
      input_idx  <= input_nxt;
      err        <= err_nxt;
      if (state == S_IDLE && start) begin
        no_layers_q <= no_layers;
        n_in_q      <= n_in;
        nl_q        <= nl_flat;
        af_q        <= af_flat;
      end
    end
  end

  assign mac_valid = (state == S_MAC);
  assign act_valid = (state == S_ACT);
  assign mac_first = mac_valid && (input_idx == '0);
  assign mac_last  = mac_valid && (input_idx == k_cur - 1'b1);
  assign af_sel    = af_cur;
  assign busy      = (state == S_CHECK) || (state == S_MAC) || (state == S_ACT);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: a reference model queues the
// expected MAC/ACT beats per run and a negedge monitor pops and compares them.
module tb_nn_layer_sequencer;

  typedef struct packed {
    logic       is_act;
    logic [5:0] layer;
    logic [5:0] neuron;
    logic [5:0] inp;
    logic       first;
    logic       last;
    logic [1:0] af;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  no_layers = '0;
  logic [5:0]  n_in = '0;
  logic [29:0] nl_flat = '0;
  logic [9:0]  af_flat = '0;
  logic        mac_valid, mac_ready, mac_first, mac_last;
  logic        act_valid, act_ready;
  logic [1:0]  af_sel;
  logic [5:0]  layer_idx, neuron_idx, input_idx;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc, done_cnt, err_cyc, err_cnt, busy_cnt, macv_cnt;
  beat_t exp_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_snap = '0;

  nn_layer_sequencer #(.MAX_LAYERS(5), .NW(6), .AFW(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .no_layers(no_layers), .n_in(n_in), .nl_flat(nl_flat), .af_flat(af_flat),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_first(mac_first), .mac_last(mac_last),
    .act_valid(act_valid), .act_ready(act_ready), .af_sel(af_sel),
    .layer_idx(layer_idx), .neuron_idx(neuron_idx), .input_idx(input_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] snap();
    return 32'({busy, done, err, mac_valid, act_valid, mac_first, mac_last,
                af_sel, layer_idx, neuron_idx, input_idx});
  endfunction

  // Reference model: expected beat sequence and cycles from start to done.
  function automatic int build_expect(input int nlay, input int nin,
                                      input logic [29:0] nl, input logic [9:0] af);
    int lat, kk, nn;
    lat = 2;
    for (int l = 0; l < nlay; l++) begin
      kk = (l == 0) ? nin : int'(nl[(l-1)*6 +: 6]);
      nn = int'(nl[l*6 +: 6]);
      for (int n = 0; n < nn; n++) begin
        for (int i = 0; i < kk; i++)
          exp_q.push_back('{1'b0, 6'(l), 6'(n), 6'(i), i == 0, i == kk - 1, af[l*2 +: 2]});
        exp_q.push_back('{1'b1, 6'(l), 6'(n), 6'(kk - 1), 1'b0, 1'b0, af[l*2 +: 2]});
        lat += kk + 1;
      end
    end
    return lat;
  endfunction

  always @(negedge clk) begin
    beat_t got, exp;
    if (!rst) begin
      if (busy) check_val("valid_excl", 32'(mac_valid & act_valid), 32'd0);
      if (hold_pend) check_val("hold_stable", snap(), hold_snap);
      hold_pend = (mac_valid && !mac_ready) || (act_valid && !act_ready);
      hold_snap = snap();
      if ((mac_valid && mac_ready) || (act_valid && act_ready)) begin
        got = '{act_valid, layer_idx, neuron_idx, input_idx, mac_first, mac_last, af_sel};
        check_val("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check_val("beat", 32'(got), 32'(exp));
        end
      end
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (err) begin err_cyc = cyc; err_cnt++; end
      busy_cnt += int'(busy);
      macv_cnt += int'(mac_valid);
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic run_cfg(input string tag, input int nlay, input int nin,
                         input logic [29:0] nl, input logic [9:0] af,
                         input int stall_at, input int stall_len,
                         input bit perturb, input int rst_at);
    int lat, c0;
    lat = build_expect(nlay, nin, nl, af);
    no_layers = 6'(nlay);
    n_in      = 6'(nin);
    nl_flat   = nl;
    af_flat   = af;
    done_cyc  = -1;
    done_cnt  = 0;
    c0        = cyc;
    start     = 1'b1;
    for (int i = 1; i <= lat + stall_len + 10; i++) begin
      @(posedge clk); #2;
      start = perturb && (i == 3);
      if (perturb && i == 4) begin
        nl_flat   = {5{6'd7}};
        no_layers = 6'd1;
        n_in      = 6'd3;
      end
      mac_ready = !(i >= stall_at && i < stall_at + stall_len);
      if (rst_at > 0 && i == rst_at) begin
        check_val({tag, "_in_act_l1"}, 32'({act_valid, layer_idx}), 32'({1'b1, 6'd1}));
        rst = 1'b1;
      end
      if (rst_at > 0 && i == rst_at + 1) begin
        check_val({tag, "_rst_outputs"}, snap(), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        break;
      end
      if (done_cyc >= 0) break;
    end
    mac_ready = 1'b1;
    if (rst_at > 0) begin
      check_val({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    end else begin
      check_val({tag, "_done_latency"}, 32'(done_cyc - c0), 32'(lat + stall_len));
      check_val({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check_val({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_err(input string tag, input int nlay, input int nin, input logic [29:0] nl);
    int c0;
    no_layers = 6'(nlay);
    n_in      = 6'(nin);
    nl_flat   = nl;
    af_flat   = 10'h3ff;
    err_cyc   = -1;
    err_cnt   = 0;
    busy_cnt  = 0;
    macv_cnt  = 0;
    c0        = cyc;
    start     = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
    end
    check_val({tag, "_err_at"}, 32'(err_cyc - c0), 32'd2);
    check_val({tag, "_err_pulses"}, 32'(err_cnt), 32'd1);
    check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd1);
    check_val({tag, "_mac_valid_cycles"}, 32'(macv_cnt), 32'd0);
  endtask

  localparam logic [29:0] NL_BASE = {6'd0, 6'd0, 6'd0, 6'd1, 6'd2};
  localparam logic [9:0]  AF_BASE = {2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

  initial begin
    mac_ready = 1'b1;
    act_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_val("reset_outputs", snap(), 32'd0);
    rst = 1'b0;

    run_cfg("base", 2, 2, NL_BASE, AF_BASE, 0, 0, 1'b0, 0);
    run_cfg("stall", 2, 2, NL_BASE, AF_BASE, 5, 3, 1'b0, 0);
    run_err("zero_layers", 0, 2, NL_BASE);
    run_err("nl1_zero", 2, 2, {6'd0, 6'd0, 6'd0, 6'd0, 6'd2});
    run_err("n_in_zero", 2, 0, NL_BASE);
    run_cfg("rst_mid", 2, 2, NL_BASE, AF_BASE, 0, 0, 1'b0, 10);
    run_cfg("after_rst", 2, 2, NL_BASE, AF_BASE, 0, 0, 1'b0, 0);
    run_cfg("perturb", 2, 2, NL_BASE, AF_BASE, 0, 0, 1'b1, 0);
    run_cfg("max_layers", 5, 1, {5{6'd1}}, {2'd3, 2'd2, 2'd1, 2'd0, 2'd3}, 0, 0, 1'b0, 0);
    run_err("six_layers", 6, 1, {5{6'd1}});
    run_cfg("wide", 3, 3, {6'd0, 6'd0, 6'd2, 6'd1, 6'd3}, {2'd0, 2'd0, 2'd3, 2'd0, 2'd2}, 0, 0, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
